// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Sliced down to WIDTH by the users; reset period is all-ones.
    localparam logic [63:0] PERIOD_DEFAULT = '1;

endpackage

// File: rtl/pwm_timebase.sv
// Shared up/up-down counter with shadowed period and alignment mode.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] period_in,
    input  logic             period_we,
    output logic [WIDTH-1:0] cnt,
    output logic             load
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] PER_RST = PERIOD_DEFAULT[WIDTH-1:0];

    logic [WIDTH-1:0] per_sh;
    logic [WIDTH-1:0] per_act;
    logic [WIDTH-1:0] per_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             mode_sh;
    logic             mode_act;
    logic             mode_nxt;
    logic             bnd;
    dir_e             dir;
    dir_e             dir_nxt;

    // Boundary: the cycle whose successor restarts the period at cnt == 0.
    always_comb begin
        bnd = 1'b0;
        if (per_act == '0) begin
            bnd = 1'b1;
        end else if (mode_act == MODE_EDGE) begin
            bnd = (cnt >= per_act);
        end else if (dir == DIR_DOWN) begin
            bnd = (cnt <= ONE);
        end else begin
            bnd = (per_act == ONE) && (cnt != '0);
        end
    end

    assign load     = bnd || !en;
    assign per_nxt  = period_we ? period_in : per_sh;
    assign mode_nxt = period_we ? mode_in : mode_sh;

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (en && !bnd) begin
            if (mode_act == MODE_EDGE) begin
                cnt_nxt = cnt + ONE;
            end else if (dir == DIR_DOWN || cnt >= per_act) begin
                cnt_nxt = cnt - ONE;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            per_sh   <= PER_RST;
            per_act  <= PER_RST;
            mode_sh  <= MODE_EDGE;
            mode_act <= MODE_EDGE;
        end else begin
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            per_sh  <= per_nxt;
            mode_sh <= mode_nxt;
            if (load) begin
                per_act  <= per_nxt;
                mode_act <= mode_nxt;
            end
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: one shared timebase, per-channel shadowed duty compare.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode_in,
    input  logic [WIDTH-1:0]          period_in,
    input  logic                      period_we,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic [CHANNELS-1:0]       duty_we,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end
);

    logic [WIDTH-1:0]    cnt;
    logic                load;
    logic [CHANNELS-1:0] hit;

    pwm_timebase #(
        .WIDTH(WIDTH)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode_in   (mode_in),
        .period_in (period_in),
        .period_we (period_we),
        .cnt       (cnt),
        .load      (load)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty_sh;
        logic [WIDTH-1:0] duty_act;
        logic [WIDTH-1:0] duty_nxt;

        // A write landing on a load cycle goes straight to the active copy.
        assign duty_nxt = duty_we[i] ? duty_in[i*WIDTH +: WIDTH] : duty_sh;
        assign hit[i]   = (cnt < duty_act);

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_sh  <= '0;
                duty_act <= '0;
            end else begin
                duty_sh <= duty_nxt;
                if (load) begin
                    duty_act <= duty_nxt;
                end
            end
        end
    end

    // cnt == 0 only ever occurs on the first cycle of a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out    <= '0;
            period_end <= 1'b0;
        end else begin
            pwm_out    <= en ? hit : '0;
            period_end <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: phase-based reference model plus vectors.
module tb_pwm_multi_gen;

    localparam int W = 8;
    localparam int N = 4;
    localparam int PMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode_in;
    logic [W-1:0] period_in;
    logic         period_we;
    logic [N*W-1:0] duty_in;
    logic [N-1:0] duty_we;
    logic [N-1:0] pwm_out;
    logic         period_end;

    always #5 clk = ~clk;

    pwm_multi_gen #(
        .WIDTH(W),
        .CHANNELS(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode_in    (mode_in),
        .period_in  (period_in),
        .period_we  (period_we),
        .duty_in    (duty_in),
        .duty_we    (duty_we),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: position k inside the period, counter derived from k.
    int       m_k;
    int       m_psh, m_pact;
    bit       m_msh, m_mact;
    int       m_dsh[N];
    int       m_dact[N];
    logic [N-1:0] exp_pwm;
    logic     exp_pe;

    function automatic int m_len();
        if (m_mact == 1'b0) return m_pact + 1;
        return (m_pact == 0) ? 1 : 2 * m_pact;
    endfunction

    function automatic int m_cnt();
        if (m_mact == 1'b0) return m_k;
        return (m_k <= m_pact) ? m_k : 2 * m_pact - m_k;
    endfunction

    task automatic model_step();
        bit bnd;
        int c;
        if (rst) begin
            m_k = 0;
            m_psh = PMAX;
            m_pact = PMAX;
            m_msh = 1'b0;
            m_mact = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_dsh[i] = 0;
                m_dact[i] = 0;
            end
            exp_pwm = '0;
            exp_pe = 1'b0;
        end else begin
            c = m_cnt();
            for (int i = 0; i < N; i++)
                exp_pwm[i] = en && (c < m_dact[i]);
            exp_pe = en && (m_k == 0);
            bnd = !en || (m_k == m_len() - 1);
            if (period_we) begin
                m_psh = int'(period_in);
                m_msh = mode_in;
            end
            for (int i = 0; i < N; i++)
                if (duty_we[i]) m_dsh[i] = int'(duty_in[i*W +: W]);
            if (bnd) begin
                m_pact = m_psh;
                m_mact = m_msh;
                for (int i = 0; i < N; i++) m_dact[i] = m_dsh[i];
            end
            m_k = bnd ? 0 : m_k + 1;
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pwm_out", int'(pwm_out), int'(exp_pwm));
        chk("period_end", int'(period_end), int'(exp_pe));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_duty(int ch, int d);
        duty_in[ch*W +: W] = W'(d);
        duty_we = '0;
        duty_we[ch] = 1'b1;
        tick();
        duty_we = '0;
    endtask

    task automatic wr_period(int p, bit m);
        period_in = W'(p);
        mode_in = m;
        period_we = 1'b1;
        tick();
        period_we = 1'b0;
    endtask

    task automatic wait_k(int k);
        int g = 0;
        while (m_k != k && g < 600) begin
            tick();
            g++;
        end
        if (m_k != k) chk("wait_k", m_k, k);
    endtask

    // Measures one full period from a period_end pulse to the next one.
    task automatic measure(int ch, output int high, output int len);
        int g = 0;
        high = 0;
        len = 0;
        while (!period_end && g < 600) begin
            tick();
            g++;
        end
        if (!period_end) begin
            chk("wait_period_end", 0, 1);
            return;
        end
        do begin
            high += int'(pwm_out[ch]);
            len++;
            tick();
        end while (!period_end && len < 600);
    endtask

    typedef struct {
        bit mode;
        int p;
        int ch;
        int d;
        int high;
        int len;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int h, l;
        rst = 1'b1;
        en = 1'b0;
        mode_in = 1'b0;
        period_in = '0;
        period_we = 1'b0;
        duty_in = '0;
        duty_we = '0;

        tbl[0]  = '{1'b0, 255, 0, 10, 10, 256};
        tbl[1]  = '{1'b0, 255, 1, 255, 255, 256};
        tbl[2]  = '{1'b0, 255, 2, 0, 0, 256};
        tbl[3]  = '{1'b0, 9, 3, 12, 10, 10};
        tbl[4]  = '{1'b0, 9, 0, 3, 3, 10};
        tbl[5]  = '{1'b0, 9, 1, 9, 9, 10};
        tbl[6]  = '{1'b1, 4, 1, 2, 3, 8};
        tbl[7]  = '{1'b1, 4, 2, 5, 8, 8};
        tbl[8]  = '{1'b1, 4, 3, 4, 7, 8};
        tbl[9]  = '{1'b1, 1, 0, 1, 1, 2};
        tbl[10] = '{1'b0, 0, 1, 1, 1, 1};
        tbl[11] = '{1'b0, 0, 2, 0, 0, 1};
        tbl[12] = '{1'b1, 7, 0, 1, 1, 14};

        tick();
        rst = 1'b0;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_pe", int'(period_end), 0);

        // Defaults only: P=255 edge, ch0 D=10.
        en = 1'b0;
        wr_duty(0, 10);
        en = 1'b1;
        measure(0, h, l);
        chk("dflt_high", h, 10);
        chk("dflt_len", l, 256);

        foreach (tbl[i]) begin
            do_reset();
            en = 1'b0;
            wr_period(tbl[i].p, tbl[i].mode);
            wr_duty(tbl[i].ch, tbl[i].d);
            en = 1'b1;
            measure(tbl[i].ch, h, l);
            chk($sformatf("vec%0d_high", i), h, tbl[i].high);
            chk($sformatf("vec%0d_len", i), l, tbl[i].len);
        end

        // Mid-period write is deferred; boundary write is immediate.
        do_reset();
        en = 1'b0;
        wr_period(9, 1'b0);
        wr_duty(0, 3);
        en = 1'b1;
        wait_k(5);
        wr_duty(0, 7);
        measure(0, h, l);
        chk("shadow_next_high", h, 7);
        chk("shadow_next_len", l, 10);
        wait_k(9);
        wr_duty(0, 2);
        measure(0, h, l);
        chk("wthru_high", h, 2);

        // Disable mid-period, reprogram, re-enable.
        wait_k(4);
        en = 1'b0;
        tick();
        chk("dis_pwm", int'(pwm_out), 0);
        chk("dis_pe", int'(period_end), 0);
        wr_duty(0, 6);
        en = 1'b1;
        tick();
        chk("reen_pe", int'(period_end), 1);
        measure(0, h, l);
        chk("reen_high", h, 6);
        chk("reen_len", l, 10);

        // Reset mid-period restores all defaults.
        do_reset();
        en = 1'b0;
        wr_duty(0, 200);
        wr_duty(1, 50);
        en = 1'b1;
        wait_k(100);
        rst = 1'b1;
        tick();
        chk("rst_mid_pwm", int'(pwm_out), 0);
        chk("rst_mid_pe", int'(period_end), 0);
        rst = 1'b0;
        measure(0, h, l);
        chk("rst_mid_high", h, 0);
        chk("rst_mid_len", l, 256);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 19) != 0);
            period_we = ($urandom_range(0, 15) == 0);
            period_in = W'($urandom_range(0, 12));
            mode_in = $urandom_range(0, 1) != 0;
            duty_we = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++)
                duty_in[i*W +: W] = W'($urandom_range(0, 14));
            tick();
        end
        rst = 1'b0;
        period_we = 1'b0;
        duty_we = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator, successor to the single-channel 8-bit PWM block. One shared timebase drives CHANNELS independent duty comparators. Adds programmable period, edge- or center-aligned mode, shadowed (glitch-free) duty/period/mode updates at period boundaries, an enable, and a period-boundary strobe. It sits between register/control logic and output pads or motor/LED drivers.

Parameters:
WIDTH, 8, bit width of counter, period and each duty value
CHANNELS, 4, number of independent PWM outputs

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = run timebase; 0 = hold counter at 0, outputs low
mode_in  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
period_in  input  WIDTH  period value P (shadowed)
period_we  input  1  write period_in/mode_in into shadow registers
duty_in  input  CHANNELS*WIDTH  duty D per channel; channel i at bits [i*WIDTH +: WIDTH]
duty_we  input  CHANNELS  per-channel write strobe into that channel's shadow duty
pwm_out  output  CHANNELS  registered PWM outputs
period_end  output  1  one-cycle registered pulse aligned with the first output cycle of each period

Behaviour:
- Reset (rst=1 at clock edge): cnt=0, dir=up, shadow and active duty=0, shadow and active period=all-ones, shadow and active mode=edge, pwm_out=0, period_end=0. Reset mid-period aborts immediately; outputs low the cycle after.
- Timebase, edge mode: cnt 0,1..P, then 0; period length P+1 cycles. P=0: cnt stays 0; every cycle is a boundary.
- Timebase, center mode: cnt 0,1..P,P-1..1, then 0; dir flips down at cnt==P and back to up at cnt==1->0. Length 2P cycles. P=0: cnt stays 0; every cycle is a boundary.
- Boundary cycle: the cycle where next cnt == 0, i.e. edge: cnt>=P_act; center: dir=down and cnt==1, or P_act==0.
- Shadowing: duty_we[i] writes the shadow duty[i]; period_we writes the shadow period and mode. On a boundary cycle, active <= shadow. A write in the boundary cycle itself is written through: the new value becomes active directly. No active value ever changes mid-period.
- Compare: pwm_out[i](t+1) = (cnt(t) < duty_act[i](t)). Latency: 1 cycle from counter value.
- Edge high time = min(D, P+1) cycles. D=0 gives constant low. D>P gives constant high.
- Center high time = 0 for D=0; 2D-1 for 1<=D<=P; 2P (constant high) for D>P. High pulse is centred on cnt==0.
- period_end(t+1) = 1 when cnt(t)==0 and en=1 and the previous cycle was a boundary (or the first cycle after en rises).
- en=0: cnt<=0, dir<=up, pwm_out<=0, period_end<=0. Shadow→active transfer happens every cycle while disabled. On en 0->1 the first period starts at cnt=0 using the latest written values.
- Mode change takes effect only at a boundary. The new period then starts at cnt=0, dir=up.
- Arithmetic: all compares are unsigned WIDTH-bit. The counter never exceeds P_act, so no wrap-around beyond the period.

Decomposition:
- Shared package/header pwm_pkg: MODE_EDGE=1'b0, MODE_CENTER=1'b1, DIR_UP/DIR_DOWN, default period constant (all-ones).
- One sub-module, pwm_timebase: cnt, dir, boundary flag, shadow/active period and mode.
- Per-channel shadow/active duty and compare live in a generate loop in pwm_multi_gen.

Test Plan:
- Reset defaults (P=255, edge), en=1, write ch0 D=10 -> ch0 high 10 cycles, low 246, period 256; other channels constantly low; period_end every 256 cycles.
- Edge, P=255, D=255 -> 255 high, 1 low. D=0 -> constant low. P=9, D=12 -> constant high.
- Shadow: P=9, D=3; write D=7 at cnt=5 -> current period still high 3 cycles; next period high 7. Write at the boundary cycle -> the new period uses 7 immediately.
- Center: period_we with P=4, mode=1; ch1 D=2 -> period 8 cycles, ch1 high 3 cycles centred on cnt=0. ch2 D=5 -> constant high.
- Disable: en low at cnt=4 -> next cycle all outputs 0, cnt=0. Write D=6 while disabled, raise en -> first period uses D=6 and period_end fires.
- Reset mid-period (rst=1 for 1 cycle at cnt=100) -> outputs 0 next cycle; all active and shadow values return to defaults.
